// File: rtl/parking_kiosk_pkg.sv
// Shared parking definitions: kiosk state encoding and widths common with the controller.
// Constants only; no logic, no latency, no backpressure.
package parking_kiosk_pkg;

    localparam int PASSCODE_W = 8;
    localparam int CAP_W      = 5;

    localparam logic [2:0] KS_IDLE     = 3'd0;
    localparam logic [2:0] KS_ENT_REQ  = 3'd1;
    localparam logic [2:0] KS_ENT_WAIT = 3'd2;
    localparam logic [2:0] KS_EXT_REQ  = 3'd3;
    localparam logic [2:0] KS_EXT_WAIT = 3'd4;
    localparam logic [2:0] KS_COOL     = 3'd5;

    typedef enum logic [2:0] {
        S_IDLE     = KS_IDLE,
        S_ENT_REQ  = KS_ENT_REQ,
        S_ENT_WAIT = KS_ENT_WAIT,
        S_EXT_REQ  = KS_EXT_REQ,
        S_EXT_WAIT = KS_EXT_WAIT,
        S_COOL     = KS_COOL
    } kiosk_state_t;

endpackage

// File: rtl/parking_kiosk_pending.sv
// Per-direction pending-request latches plus the entry passcode latch; one cycle to latch,
// fresh pulses bypass to the outputs. Never stalls: a pulse on an already-set flag is dropped.
module kiosk_pending
    import parking_kiosk_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  car_arrive,
    input  logic                  car_depart,
    input  logic [PASSCODE_W-1:0] passcode_key,
    input  logic                  take_in,
    input  logic                  take_out,
    output logic                  want_in,
    output logic                  want_out,
    output logic [PASSCODE_W-1:0] code
);

    logic                  pend_in;
    logic                  pend_out;
    logic [PASSCODE_W-1:0] code_q;

    // A pulse arriving this cycle is visible immediately so an idle kiosk can dispatch it.
    assign want_in  = pend_in | car_arrive;
    assign want_out = pend_out | car_depart;
    assign code     = pend_in ? code_q : passcode_key;

    always_ff @(posedge clk) begin
        if (reset) begin
            pend_in  <= 1'b0;
            pend_out <= 1'b0;
            code_q   <= '0;
        end else begin
            // When consuming a latched flag, a same-cycle pulse re-arms it.
            if (take_in) begin
                pend_in <= pend_in & car_arrive;
            end else if (car_arrive) begin
                pend_in <= 1'b1;
            end

            if (car_arrive && (!pend_in || take_in)) begin
                code_q <= passcode_key;
            end

            if (take_out) begin
                pend_out <= pend_out & car_depart;
            end else if (car_depart) begin
                pend_out <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/parking_kiosk.sv
// Kiosk initiator: turns lane events into 1-cycle enter/exit requests and judges grant/deny.
// Request one cycle after dispatch, grant 3 cycles after request; no backpressure, requests queue one-deep.
module parking_kiosk
    import parking_kiosk_pkg::*;
#(
    parameter int TIMEOUT = 6,
    parameter int GAP     = 2,
    parameter int CNT_W   = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  car_arrive,
    input  logic                  car_depart,
    input  logic [PASSCODE_W-1:0] passcode_key,
    input  logic                  entry_gate_open,
    input  logic                  exit_gate_open,
    input  logic                  lot_full,
    output logic [PASSCODE_W-1:0] passcode_out,
    output logic                  enter_req,
    output logic                  exit_req,
    output logic                  busy,
    output logic                  grant_pulse,
    output logic                  deny_pulse,
    output logic [CNT_W-1:0]      deny_count
);

    localparam int TMAX = (TIMEOUT > GAP) ? TIMEOUT : GAP;
    localparam int TW   = $clog2(TMAX + 1);

    kiosk_state_t          state;
    kiosk_state_t          state_nx;
    logic [TW-1:0]         timer;
    logic [TW-1:0]         timer_nx;
    logic                  enter_nx;
    logic                  exit_nx;
    logic [PASSCODE_W-1:0] pass_nx;
    logic                  grant_nx;
    logic                  deny_hit;
    logic                  take_in;
    logic                  take_out;
    logic                  want_in;
    logic                  want_out;
    logic [PASSCODE_W-1:0] code;

    kiosk_pending u_pending (
        .clk          (clk),
        .reset        (reset),
        .car_arrive   (car_arrive),
        .car_depart   (car_depart),
        .passcode_key (passcode_key),
        .take_in      (take_in),
        .take_out     (take_out),
        .want_in      (want_in),
        .want_out     (want_out),
        .code         (code)
    );

    always_comb begin
        state_nx = state;
        timer_nx = timer;
        enter_nx = 1'b0;
        exit_nx  = 1'b0;
        pass_nx  = '0;
        grant_nx = 1'b0;
        deny_hit = 1'b0;
        take_in  = 1'b0;
        take_out = 1'b0;

        case (state)
            S_IDLE: begin
                if (want_in) begin
                    take_in = 1'b1;
                    if (lot_full) begin
                        // Full lot: deny locally without bothering the controller.
                        deny_hit = 1'b1;
                        state_nx = S_COOL;
                        timer_nx = '0;
                    end else begin
                        enter_nx = 1'b1;
                        pass_nx  = code;
                        state_nx = S_ENT_REQ;
                    end
                end else if (want_out) begin
                    take_out = 1'b1;
                    exit_nx  = 1'b1;
                    state_nx = S_EXT_REQ;
                end
            end

            S_ENT_REQ: begin
                // Controller samples the code the cycle after the request, so keep it.
                pass_nx  = passcode_out;
                state_nx = S_ENT_WAIT;
                timer_nx = '0;
            end

            S_ENT_WAIT: begin
                pass_nx = passcode_out;
                if (entry_gate_open) begin
                    grant_nx = 1'b1;
                    pass_nx  = '0;
                    state_nx = S_COOL;
                    timer_nx = '0;
                end else if (timer == TW'(TIMEOUT - 1)) begin
                    deny_hit = 1'b1;
                    pass_nx  = '0;
                    state_nx = S_COOL;
                    timer_nx = '0;
                end else begin
                    timer_nx = timer + TW'(1);
                end
            end

            S_EXT_REQ: begin
                state_nx = S_EXT_WAIT;
                timer_nx = '0;
            end

            S_EXT_WAIT: begin
                if (exit_gate_open) begin
                    grant_nx = 1'b1;
                    state_nx = S_COOL;
                    timer_nx = '0;
                end else if (timer == TW'(TIMEOUT - 1)) begin
                    deny_hit = 1'b1;
                    state_nx = S_COOL;
                    timer_nx = '0;
                end else begin
                    timer_nx = timer + TW'(1);
                end
            end

            S_COOL: begin
                if (timer == TW'(GAP - 1)) begin
                    state_nx = S_IDLE;
                    timer_nx = '0;
                end else begin
                    timer_nx = timer + TW'(1);
                end
            end

            default: begin
                state_nx = S_IDLE;
                timer_nx = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= S_IDLE;
            timer        <= '0;
            enter_req    <= 1'b0;
            exit_req     <= 1'b0;
            passcode_out <= '0;
            busy         <= 1'b0;
            grant_pulse  <= 1'b0;
            deny_pulse   <= 1'b0;
            deny_count   <= '0;
        end else begin
            state        <= state_nx;
            timer        <= timer_nx;
            enter_req    <= enter_nx;
            exit_req     <= exit_nx;
            passcode_out <= pass_nx;
            busy         <= (state_nx != S_IDLE);
            grant_pulse  <= grant_nx;
            deny_pulse   <= deny_hit;
            if (deny_hit && (deny_count != {CNT_W{1'b1}})) begin
                deny_count <= deny_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_parking_kiosk.sv
// Kiosk bench: behavioural controller responder plus a transaction-schedule reference model.
module tb_parking_kiosk;

    localparam int         TIMEOUT   = 6;
    localparam int         GAP       = 2;
    localparam int         CNT_W     = 8;
    localparam int         MAXC      = 16384;
    localparam logic [7:0] GOOD_CODE = 8'hFF;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             car_arrive = 1'b0;
    logic             car_depart = 1'b0;
    logic [7:0]       passcode_key = 8'h00;
    logic             entry_gate_open;
    logic             exit_gate_open;
    logic             lot_full;
    logic [7:0]       passcode_out;
    logic             enter_req;
    logic             exit_req;
    logic             busy;
    logic             grant_pulse;
    logic             deny_pulse;
    logic [CNT_W-1:0] deny_count;

    always #5 clk = ~clk;

    parking_kiosk #(.TIMEOUT(TIMEOUT), .GAP(GAP), .CNT_W(CNT_W)) dut (
        .clk             (clk),
        .reset           (reset),
        .car_arrive      (car_arrive),
        .car_depart      (car_depart),
        .passcode_key    (passcode_key),
        .entry_gate_open (entry_gate_open),
        .exit_gate_open  (exit_gate_open),
        .lot_full        (lot_full),
        .passcode_out    (passcode_out),
        .enter_req       (enter_req),
        .exit_req        (exit_req),
        .busy            (busy),
        .grant_pulse     (grant_pulse),
        .deny_pulse      (deny_pulse),
        .deny_count      (deny_count)
    );

    // Controller responder: samples the code one cycle after a request, opens the gate the next.
    logic ctl_clear = 1'b1;
    int   max_cap = 3;
    int   ctl_count;
    logic ent_stage, ext_stage;

    always @(posedge clk) begin
        if (ctl_clear) begin
            ctl_count       <= 0;
            ent_stage       <= 1'b0;
            ext_stage       <= 1'b0;
            entry_gate_open <= 1'b0;
            exit_gate_open  <= 1'b0;
        end else begin
            ent_stage       <= enter_req;
            ext_stage       <= exit_req;
            entry_gate_open <= 1'b0;
            exit_gate_open  <= 1'b0;
            if (ent_stage && passcode_out == GOOD_CODE && ctl_count < max_cap) begin
                entry_gate_open <= 1'b1;
                ctl_count       <= ctl_count + 1;
            end
            if (ext_stage && ctl_count > 0) begin
                exit_gate_open <= 1'b1;
                ctl_count      <= ctl_count - 1;
            end
        end
    end

    assign lot_full = (ctl_count >= max_cap);

    // Reference model: each dispatched request lays out its expected output timeline.
    bit       exp_ent   [MAXC];
    bit       exp_ext   [MAXC];
    bit       exp_busy  [MAXC];
    bit       exp_grant [MAXC];
    bit       exp_deny  [MAXC];
    bit [7:0] exp_pass  [MAXC];

    int       cyc = 0;
    int       free_at = 0;
    int       m_occ = 0;
    int       m_dc = 0;
    bit       m_pin = 1'b0;
    bit       m_pout = 1'b0;
    bit [7:0] m_code = 8'h00;
    bit       armed = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
        n_cmp++;
        if (got !== expv) begin
            n_bad++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", tag, cyc, got, expv);
        end
    endtask

    task automatic mark_busy(input int d, input int last_active);
        for (int k = d + 1; k < last_active + GAP; k++) exp_busy[k] = 1'b1;
        free_at = last_active + GAP;
    endtask

    task automatic issue_entry(input int d, input bit [7:0] code, input bit full);
        int e;
        if (full) begin
            e = d + 1;
            exp_deny[e] = 1'b1;
        end else begin
            exp_ent[d + 1] = 1'b1;
            if (code == GOOD_CODE) begin
                e = d + 4;
                exp_grant[e] = 1'b1;
                m_occ++;
            end else begin
                e = d + 2 + TIMEOUT;
                exp_deny[e] = 1'b1;
            end
            for (int k = d + 1; k < e; k++) exp_pass[k] = code;
        end
        mark_busy(d, e);
    endtask

    task automatic issue_exit(input int d);
        int e;
        exp_ext[d + 1] = 1'b1;
        if (m_occ > 0) begin
            e = d + 4;
            exp_grant[e] = 1'b1;
            m_occ--;
        end else begin
            e = d + 2 + TIMEOUT;
            exp_deny[e] = 1'b1;
        end
        mark_busy(d, e);
    endtask

    always @(posedge clk) begin
        int       c;
        bit [7:0] code;
        bit       full;
        c = cyc;
        if (reset) begin
            armed = 1'b1;
            for (int k = c + 1; k < c + 32; k++) begin
                exp_ent[k] = 0; exp_ext[k] = 0; exp_busy[k] = 0;
                exp_grant[k] = 0; exp_deny[k] = 0; exp_pass[k] = 0;
            end
            free_at = c + 1;
            m_pin   = 1'b0;
            m_pout  = 1'b0;
            m_code  = 8'h00;
            m_dc    = 0;
        end else begin
            full = (m_occ >= max_cap);
            code = m_pin ? m_code : passcode_key;
            if (c >= free_at && (m_pin || car_arrive)) begin
                m_pin = m_pin && car_arrive;
                if (car_arrive) m_code = passcode_key;
                if (car_depart) m_pout = 1'b1;
                issue_entry(c, code, full);
            end else if (c >= free_at && (m_pout || car_depart)) begin
                m_pout = m_pout && car_depart;
                issue_exit(c);
            end else begin
                if (car_arrive && !m_pin) m_code = passcode_key;
                m_pin  = m_pin || car_arrive;
                m_pout = m_pout || car_depart;
            end
            if (exp_deny[c + 1] && m_dc < 255) m_dc++;
        end
        cyc = c + 1;
    end

    always @(negedge clk) begin
        if (armed) begin
            chk("enter_req",    32'(enter_req),    32'(exp_ent[cyc]));
            chk("exit_req",     32'(exit_req),     32'(exp_ext[cyc]));
            chk("passcode_out", 32'(passcode_out), 32'(exp_pass[cyc]));
            chk("busy",         32'(busy),         32'(exp_busy[cyc]));
            chk("grant_pulse",  32'(grant_pulse),  32'(exp_grant[cyc]));
            chk("deny_pulse",   32'(deny_pulse),   32'(exp_deny[cyc]));
            chk("deny_count",   32'(deny_count),   32'(m_dc));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_n(input int n);
        car_arrive = 1'b0;
        car_depart = 1'b0;
        repeat (n) tick();
    endtask

    task automatic pulse(input bit a, input bit d, input logic [7:0] key);
        car_arrive   = a;
        car_depart   = d;
        passcode_key = key;
        tick();
        car_arrive = 1'b0;
        car_depart = 1'b0;
    endtask

    initial begin
        repeat (3) tick();
        reset     = 1'b0;
        ctl_clear = 1'b0;
        idle_n(2);

        pulse(1, 0, 8'hFF);              // valid entry, count 0 -> 1
        idle_n(12);
        pulse(1, 0, 8'h12);              // bad code, timeout deny
        idle_n(14);
        max_cap = 1;                     // lot now full
        idle_n(1);
        pulse(1, 0, 8'hFF);
        idle_n(6);
        max_cap = 3;
        pulse(1, 0, 8'hFF);              // count 1 -> 2
        idle_n(10);
        pulse(1, 1, 8'hFF);              // simultaneous: entry then exit
        idle_n(24);
        pulse(0, 1, 8'h00);              // drain to empty
        idle_n(11);
        pulse(0, 1, 8'h00);
        idle_n(11);
        for (int i = 0; i < 300; i++) begin
            pulse(0, 1, 8'($urandom));
            idle_n(11);
        end

        pulse(1, 0, 8'hFF);              // reset during ENT_WAIT timer=1
        idle_n(2);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        idle_n(3);
        pulse(1, 0, 8'hFF);
        idle_n(12);

        max_cap = 4;
        for (int i = 0; i < 4000; i++) begin
            car_arrive   = ($urandom % 7) == 0;
            car_depart   = ($urandom % 7) == 0;
            passcode_key = ($urandom % 2) ? GOOD_CODE : 8'($urandom);
            reset        = (cyc >= free_at) && (($urandom % 300) == 0);
            tick();
        end
        reset = 1'b0;
        idle_n(20);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
